alu_ctrl_issue: RTL and testbench
=================================

Name: alu_ctrl_issue

Overview:
- Producer end of the ALU control/operand interface (ALUCtrl, data1, data2).
- Decodes one instruction's opcode/funct3/funct7, picks the operands, and presents a registered ALU request to the execute stage.
- Uses a valid/ready handshake in both directions and has a 2-entry skid buffer, so the execute stage can stall without creating a combinational ready path upstream.
- Sits between the decode/register-read stage and the ALU.

Parameters:
- DATA_W, 32, operand width; must match the ALU data width.
- SHAMT_W, 5, number of low operand bits kept for shift amounts.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  upstream has an instruction this cycle.
- ready_o  output  1  block can accept; registered, equals !skid_valid.
- opcode_i  input  7  instruction[6:0].
- funct3_i  input  3  instruction[14:12].
- funct7_i  input  7  instruction[31:25].
- rs1_data_i  input  DATA_W  register-file read data for rs1.
- rs2_data_i  input  DATA_W  register-file read data for rs2.
- imm_i  input  DATA_W  sign-extended I-type immediate.
- valid_o  output  1  ALU request valid.
- ready_i  input  1  execute stage accepts the request.
- ALUCtrl_o  output  3  ALU operation code.
- data1_o  output  DATA_W  ALU operand 1.
- data2_o  output  DATA_W  ALU operand 2.
- illegal_o  output  1  the presented request came from an unsupported encoding.

Behaviour:
- Decode (combinational, on the input side):
  - Opcode 0110011 (R-type):
    - f7=0000000: f3 000 -> ADD, 111 -> AND, 100 -> XOR, 001 -> SLL.
    - f7=0100000: f3 000 -> SUB, 101 -> SRA.
    - f7=0000001: f3 000 -> MUL.
  - Opcode 0010011 (I-type):
    - f3 000 -> ADD with data2 = imm_i.
    - f3 101 with imm_i[11:5]=0100000 -> SRA with data2 = imm_i[4:0].
  - Any other combination is illegal: ALUCtrl=ADD, data1=data2=0, illegal=1.
- Operands:
  - data1 = rs1_data_i for all legal encodings.
  - R-type data2 = rs2_data_i.
  - For SLL/SRA, data2 is masked to the low SHAMT_W bits and zero-extended to DATA_W.
- Handshake:
  - A transfer happens on any edge where valid && ready are both 1.
  - valid_o must not drop, and ALUCtrl_o/data1_o/data2_o/illegal_o must not change, while valid_o=1 and ready_i=0.
- Storage: an output register (out) plus one skid register (skid).
  - Accept into out when out is empty, or when out is draining this cycle and skid is empty.
  - Accept into skid when out is held (valid_o && !ready_i) and skid is empty.
  - When out drains and skid is full: skid moves to out; skid becomes empty.
- Latency and throughput:
  - 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
  - Full throughput of 1 per cycle while ready_i=1.
- ready_o is 0 exactly when skid is full. There is no combinational path from ready_i to ready_o.
- Simultaneous events:
  - Upstream accept, downstream drain and a skid move can all occur on one edge; ordering must be preserved (FIFO order).
  - An input with valid_i=1 while ready_o=0 is ignored. Upstream holds it.
- Reset, including mid-operation:
  - Both entries are cleared; valid_o=0, ready_o=1.
  - ALUCtrl_o=ADD (3'b011), data1_o=0, data2_o=0, illegal_o=0.
  - Any in-flight requests are discarded.
- Data outputs only change when a new entry loads into out.

Decomposition:
- Shared header: the ALU op codes ALU_AND=000, ALU_XOR=001, ALU_SLL=010, ALU_ADD=011, ALU_SUB=100, ALU_MUL=101, ALU_SRA=110 (111 reserved), and the opcode constants OP_RTYPE=0110011 and OP_ITYPE=0010011.
- Sub-module alu_issue_decode: purely combinational, holds the decode and operand-select logic. The top level holds the skid buffer.

Test Plan:
- Reset: assert rst_i with requests in flight -> next cycle valid_o=0, ready_o=1, ALUCtrl_o=011, data outputs 0.
- Streaming R-type: add/sub/mul/xor with rs1=7, rs2=3, ready_i=1 -> ALUCtrl 011/100/101/001 on consecutive cycles, each 1 cycle after its accept, data1=7, data2=3.
- Shift masking: sll with rs2=0x0000_0123 -> data2_o=0x3. srai with imm=0x0000_0405 -> ALUCtrl=110, data2_o=5.
- Stall and skid:
  - Hold ready_i=0 while presenting A then B -> A stays stable on the outputs, B lands in skid, ready_o=0 on the following cycle, C is not accepted.
  - Release ready_i -> A, B, C appear in order with no loss or duplication.
- Illegal encodings: opcode 0110011, f3=110, f7=0 (or), and opcode 1100011 -> illegal_o=1, ALUCtrl=011, data1=data2=0.
- Random stall: random valid_i/ready_i for 1000 cycles against a reference-model scoreboard -> exact in-order match and stable outputs during every stall.

Source files
------------

// File: rtl/alu_ctrl_issue_pkg.sv
// Shared constants for the ALU control issue slice.
// ALU op codes, opcodes and funct fields used by decode and issue.
package alu_ctrl_issue_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_XOR = 3'b001,
        ALU_SLL = 3'b010,
        ALU_ADD = 3'b011,
        ALU_SUB = 3'b100,
        ALU_MUL = 3'b101,
        ALU_SRA = 3'b110
    } alu_op_e;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/alu_ctrl_issue_decode.sv
// Combinational decode and operand select for one ALU request.
// In: opcode/funct3/funct7, rs1/rs2 data, imm. Out: op, data1, data2, illegal.
module alu_issue_decode
    import alu_ctrl_issue_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [DATA_W-1:0] imm,
    output logic [2:0]        alu_ctrl,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic              illegal
);

    logic              is_r;
    logic              is_i;
    logic [DATA_W-1:0] rs2_shamt;
    logic [DATA_W-1:0] imm_shamt;

    assign is_r = (opcode == OP_RTYPE);
    assign is_i = (opcode == OP_ITYPE);

    // Shift amounts keep only the low bits, zero-extended.
    assign rs2_shamt = {{(DATA_W-SHAMT_W){1'b0}},
                        rs2_data[SHAMT_W-1:0]};
    assign imm_shamt = {{(DATA_W-SHAMT_W){1'b0}},
                        imm[SHAMT_W-1:0]};

    always_comb begin
        alu_ctrl = ALU_ADD;
        data1    = '0;
        data2    = '0;
        illegal  = 1'b1;
        unique case (1'b1)
            is_r && funct7 == F7_BASE && funct3 == F3_ADD: begin
                alu_ctrl = ALU_ADD;
                data1    = rs1_data;
                data2    = rs2_data;
                illegal  = 1'b0;
            end
            is_r && funct7 == F7_BASE && funct3 == F3_AND: begin
                alu_ctrl = ALU_AND;
                data1    = rs1_data;
                data2    = rs2_data;
                illegal  = 1'b0;
            end
            is_r && funct7 == F7_BASE && funct3 == F3_XOR: begin
                alu_ctrl = ALU_XOR;
                data1    = rs1_data;
                data2    = rs2_data;
                illegal  = 1'b0;
            end
            is_r && funct7 == F7_BASE && funct3 == F3_SLL: begin
                alu_ctrl = ALU_SLL;
                data1    = rs1_data;
                data2    = rs2_shamt;
                illegal  = 1'b0;
            end
            is_r && funct7 == F7_ALT && funct3 == F3_ADD: begin
                alu_ctrl = ALU_SUB;
                data1    = rs1_data;
                data2    = rs2_data;
                illegal  = 1'b0;
            end
            is_r && funct7 == F7_ALT && funct3 == F3_SR: begin
                alu_ctrl = ALU_SRA;
                data1    = rs1_data;
                data2    = rs2_shamt;
                illegal  = 1'b0;
            end
            is_r && funct7 == F7_MUL && funct3 == F3_ADD: begin
                alu_ctrl = ALU_MUL;
                data1    = rs1_data;
                data2    = rs2_data;
                illegal  = 1'b0;
            end
            is_i && funct3 == F3_ADD: begin
                alu_ctrl = ALU_ADD;
                data1    = rs1_data;
                data2    = imm;
                illegal  = 1'b0;
            end
            // srai carries its funct7 in imm[11:5]
            is_i && funct3 == F3_SR && imm[11:5] == F7_ALT: begin
                alu_ctrl = ALU_SRA;
                data1    = rs1_data;
                data2    = imm_shamt;
                illegal  = 1'b0;
            end
            default: begin
                alu_ctrl = ALU_ADD;
                data1    = '0;
                data2    = '0;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_issue.sv
// Registered ALU request issue with a 2-entry skid buffer.
// Upstream valid_i/ready_o, downstream valid_o/ready_i; ALUCtrl/data1/data2/illegal.
module alu_ctrl_issue
    import alu_ctrl_issue_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [2:0]        ALUCtrl_o,
    output logic [DATA_W-1:0] data1_o,
    output logic [DATA_W-1:0] data2_o,
    output logic              illegal_o
);

    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        logic              ill;
    } entry_t;

    localparam entry_t ENTRY_RST = '{
        op:  ALU_ADD,
        d1:  '0,
        d2:  '0,
        ill: 1'b0
    };

    entry_t dec;
    entry_t out_q;
    entry_t skid_q;
    logic   out_valid;
    logic   skid_valid;
    logic   accept;
    logic   drain;

    alu_issue_decode #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_decode (
        .opcode   (opcode_i),
        .funct3   (funct3_i),
        .funct7   (funct7_i),
        .rs1_data (rs1_data_i),
        .rs2_data (rs2_data_i),
        .imm      (imm_i),
        .alu_ctrl (dec.op),
        .data1    (dec.d1),
        .data2    (dec.d2),
        .illegal  (dec.ill)
    );

    // ready_o depends only on a flop, never on ready_i.
    assign accept = valid_i && !skid_valid;
    assign drain  = out_valid && ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= ENTRY_RST;
            skid_q     <= ENTRY_RST;
        end else if (drain) begin
            if (skid_valid) begin
                // skid full means no accept this edge
                out_q      <= skid_q;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_q <= dec;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (!out_valid) begin
            if (accept) begin
                out_q     <= dec;
                out_valid <= 1'b1;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign ready_o   = !skid_valid;
    assign valid_o   = out_valid;
    assign ALUCtrl_o = out_q.op;
    assign data1_o   = out_q.d1;
    assign data2_o   = out_q.d2;
    assign illegal_o = out_q.ill;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Self-checking bench for alu_ctrl_issue.
// Directed cases plus randomized traffic against a queue model.
module tb_alu_ctrl_issue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [31:0] imm_i;
    logic        valid_o;
    logic        ready_i;
    logic [2:0]  ALUCtrl_o;
    logic [31:0] data1_o;
    logic [31:0] data2_o;
    logic        illegal_o;

    alu_ctrl_issue #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .opcode_i   (opcode_i),
        .funct3_i   (funct3_i),
        .funct7_i   (funct7_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .imm_i      (imm_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .ALUCtrl_o  (ALUCtrl_o),
        .data1_o    (data1_o),
        .data2_o    (data2_o),
        .illegal_o  (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        ill;
    } exp_t;

    localparam logic [6:0] R = 7'b0110011;
    localparam logic [6:0] I = 7'b0010011;
    localparam logic [6:0] B = 7'b1100011;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    bit   sb_on = 1'b0;
    bit   prev_stall = 1'b0;
    exp_t prev_out;

    task automatic chk(string tag, logic [31:0] got,
                       logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference decode straight from the instruction table.
    function automatic exp_t model(
        logic [6:0] opc, logic [2:0] f3, logic [6:0] f7,
        logic [31:0] a, logic [31:0] b, logic [31:0] im);
        exp_t e;
        e = '{op: 3'd3, d1: 32'd0, d2: 32'd0, ill: 1'b1};
        if (opc == R) begin
            if (f7 == 7'h00 && f3 == 3'd0) e = '{3'd3, a, b, 1'b0};
            if (f7 == 7'h00 && f3 == 3'd7) e = '{3'd0, a, b, 1'b0};
            if (f7 == 7'h00 && f3 == 3'd4) e = '{3'd1, a, b, 1'b0};
            if (f7 == 7'h00 && f3 == 3'd1)
                e = '{3'd2, a, b % 32, 1'b0};
            if (f7 == 7'h20 && f3 == 3'd0) e = '{3'd4, a, b, 1'b0};
            if (f7 == 7'h20 && f3 == 3'd5)
                e = '{3'd6, a, b % 32, 1'b0};
            if (f7 == 7'h01 && f3 == 3'd0) e = '{3'd5, a, b, 1'b0};
        end else if (opc == I) begin
            if (f3 == 3'd0) e = '{3'd3, a, im, 1'b0};
            if (f3 == 3'd5 && (im >> 5) % 128 == 32)
                e = '{3'd6, a, im % 32, 1'b0};
        end
        return e;
    endfunction

    task automatic drive(bit v, logic [6:0] opc, logic [2:0] f3,
                         logic [6:0] f7, logic [31:0] a,
                         logic [31:0] b, logic [31:0] im);
        valid_i    = v;
        opcode_i   = opc;
        funct3_i   = f3;
        funct7_i   = f7;
        rs1_data_i = a;
        rs2_data_i = b;
        imm_i      = im;
    endtask

    // Called mid low phase: check, take an edge, update model.
    task automatic tick();
        bit   fin;
        bit   fout;
        exp_t cur;
        exp_t e;
        cur = '{ALUCtrl_o, data1_o, data2_o, illegal_o};
        if (sb_on) begin
            chk("valid", 32'(valid_o), 32'(q.size() > 0));
            chk("ready", 32'(ready_o), 32'(q.size() < 2));
            if (valid_o && q.size() > 0) begin
                chk("op", 32'(cur.op), 32'(q[0].op));
                chk("d1", cur.d1, q[0].d1);
                chk("d2", cur.d2, q[0].d2);
                chk("ill", 32'(cur.ill), 32'(q[0].ill));
            end
            if (prev_stall) begin
                chk("hold_v", 32'(valid_o), 32'd1);
                chk("hold", 32'(cur == prev_out), 32'd1);
            end
        end
        fin  = valid_i && ready_o;
        fout = valid_o && ready_i;
        e = model(opcode_i, funct3_i, funct7_i,
                  rs1_data_i, rs2_data_i, imm_i);
        prev_stall = valid_o && !ready_i && !rst_i;
        prev_out   = cur;
        @(posedge clk_i);
        if (rst_i) begin
            q.delete();
        end else begin
            if (fout && q.size() > 0) void'(q.pop_front());
            if (fin) q.push_back(e);
        end
        @(negedge clk_i);
    endtask

    initial begin
        rst_i   = 1'b1;
        ready_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        tick();
        tick();
        rst_i = 1'b0;
        sb_on = 1'b1;

        // Reset with two requests in flight
        drive(1, R, 0, 7'h00, 7, 3, 0);
        #1 tick();
        drive(1, R, 0, 7'h20, 7, 3, 0);
        #1 tick();
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 tick();
        rst_i = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_op", 32'(ALUCtrl_o), 32'd3);
        chk("rst_d1", data1_o, 32'd0);
        chk("rst_d2", data2_o, 32'd0);
        chk("rst_ill", 32'(illegal_o), 32'd0);
        tick();

        // Streaming add/sub/mul/xor
        ready_i = 1'b1;
        drive(1, R, 0, 7'h00, 7, 3, 0);
        #1 tick();
        drive(1, R, 0, 7'h20, 7, 3, 0);
        #1;
        chk("s_add", 32'(ALUCtrl_o), 32'd3);
        chk("s_d1", data1_o, 32'd7);
        chk("s_d2", data2_o, 32'd3);
        tick();
        drive(1, R, 0, 7'h01, 7, 3, 0);
        #1 chk("s_sub", 32'(ALUCtrl_o), 32'd4);
        tick();
        drive(1, R, 4, 7'h00, 7, 3, 0);
        #1 chk("s_mul", 32'(ALUCtrl_o), 32'd5);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 chk("s_xor", 32'(ALUCtrl_o), 32'd1);
        tick();

        // Shift amount masking
        drive(1, R, 1, 7'h00, 7, 32'h123, 0);
        #1 tick();
        drive(1, I, 5, 7'h00, 32'h8000_0000, 0, 32'h405);
        #1;
        chk("sll_op", 32'(ALUCtrl_o), 32'd2);
        chk("sll_d2", data2_o, 32'h3);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("srai_op", 32'(ALUCtrl_o), 32'd6);
        chk("srai_d2", data2_o, 32'h5);
        tick();

        // Stall: A out, B skid, C held off
        ready_i = 1'b0;
        drive(1, R, 0, 7'h00, 1, 1, 0);
        #1 tick();
        drive(1, R, 4, 7'h00, 2, 2, 0);
        #1;
        chk("st_a", data1_o, 32'd1);
        chk("st_rdy1", 32'(ready_o), 32'd1);
        tick();
        drive(1, R, 0, 7'h20, 3, 3, 0);
        #1;
        chk("st_a_hold", data1_o, 32'd1);
        chk("st_rdy0", 32'(ready_o), 32'd0);
        tick();
        #1 chk("st_c_out", 32'(ready_o), 32'd0);
        tick();
        ready_i = 1'b1;
        #1 chk("rel_a", data1_o, 32'd1);
        tick();
        #1;
        chk("rel_b_op", 32'(ALUCtrl_o), 32'd1);
        chk("rel_b", data1_o, 32'd2);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rel_c_op", 32'(ALUCtrl_o), 32'd4);
        chk("rel_c", data1_o, 32'd3);
        tick();
        #1 chk("rel_empty", 32'(valid_o), 32'd0);
        tick();

        // Illegal encodings
        drive(1, R, 6, 7'h00, 9, 9, 0);
        #1 tick();
        drive(1, B, 0, 7'h00, 9, 9, 9);
        #1;
        chk("or_ill", 32'(illegal_o), 32'd1);
        chk("or_op", 32'(ALUCtrl_o), 32'd3);
        chk("or_d1", data1_o, 32'd0);
        chk("or_d2", data2_o, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("br_ill", 32'(illegal_o), 32'd1);
        chk("br_d1", data1_o, 32'd0);
        tick();

        // Random traffic; upstream holds a refused request
        for (int n = 0; n < 1000; n++) begin
            if (!(valid_i && !ready_o)) begin
                logic [6:0]  opc;
                logic [2:0]  f3;
                logic [6:0]  f7;
                logic [31:0] im;
                int          k;
                k  = int'($urandom_range(0, 11));
                f3 = 3'($urandom);
                f7 = 7'h00;
                opc = R;
                im = $urandom;
                case (k)
                    0: f3 = 3'd0;
                    1: f3 = 3'd7;
                    2: f3 = 3'd4;
                    3: f3 = 3'd1;
                    4: begin f7 = 7'h20; f3 = 3'd0; end
                    5: begin f7 = 7'h20; f3 = 3'd5; end
                    6: begin f7 = 7'h01; f3 = 3'd0; end
                    7: begin opc = I; f3 = 3'd0; end
                    8: begin
                        opc = I;
                        f3  = 3'd5;
                        im  = 32'h400 | ($urandom % 32);
                    end
                    9: begin opc = I; f3 = 3'd5; end
                    10: opc = 7'($urandom);
                    default: f7 = 7'($urandom);
                endcase
                drive($urandom_range(0, 3) != 0, opc, f3, f7,
                      $urandom, $urandom, im);
            end
            ready_i = ($urandom_range(0, 2) != 0);
            #1 tick();
        end

        ready_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 4; n++) begin
            #1 tick();
        end
        chk("drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
